// File: rtl/lfsr64_checker_if.sv
// Bus bundle between an LFSR word source and lfsr64_checker.
// The master samples generator words; the slave reports lock, error and period status.
interface lfsr64_checker_if #(
  parameter int W     = 64,
  parameter int ERR_W = 16
);
  logic             start;
  logic             in_valid;
  logic [W-1:0]     in_state;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             zero_seen;
  logic [W-1:0]     period;
  logic             period_valid;

  modport master (
    output start, in_valid, in_state,
    input  locked, err_pulse, err_count, zero_seen, period, period_valid
  );

  modport slave (
    input  start, in_valid, in_state,
    output locked, err_pulse, err_count, zero_seen, period, period_valid
  );
endinterface

// File: rtl/lfsr64_checker.sv
// Locks onto a Fibonacci LFSR word stream, counts mismatches and measures
// the sequence repeat length relative to the first word accepted after lock.
module lfsr64_checker #(
  parameter int           W          = 64,
  parameter logic [W-1:0] TAPS       = W'(64'hD800000000000000),
  parameter int           MISS_LIMIT = 3,
  parameter int           ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  lfsr64_checker_if.slave  bus
);

  localparam int MR_W = $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } state_e;

  state_e           state_r, state_s;
  logic [W-1:0]     ref_r, ref_s;
  logic [W-1:0]     origin_r, origin_s;
  logic [W-1:0]     cycle_r, cycle_s;
  logic [W-1:0]     period_r, period_s;
  logic             period_valid_r, period_valid_s;
  logic [MR_W-1:0]  miss_r, miss_s;
  logic [ERR_W-1:0] err_count_r, err_count_s;
  logic             locked_r, locked_s;
  logic             err_pulse_r, err_pulse_s;
  logic             zero_seen_r, zero_seen_s;

  logic [W-1:0]     ref_step_s, in_step_s, cycle_inc_s;
  logic [MR_W-1:0]  miss_inc_s;
  logic [ERR_W-1:0] err_inc_s;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    logic fb;
    fb = ^(s & TAPS);
    return {s[W-2:0], fb};
  endfunction

  // Next-state and next-output decode for the acquire/track machine.
  always_comb begin
    state_s        = state_r;
    ref_s          = ref_r;
    origin_s       = origin_r;
    cycle_s        = cycle_r;
    period_s       = period_r;
    period_valid_s = period_valid_r;
    miss_s         = miss_r;
    err_count_s    = err_count_r;
    locked_s       = locked_r;
    err_pulse_s    = 1'b0;
    zero_seen_s    = 1'b0;

    ref_step_s  = lfsr_step(ref_r);
    in_step_s   = lfsr_step(bus.in_state);
    cycle_inc_s = (cycle_r == '1) ? cycle_r : cycle_r + W'(1'b1);
    miss_inc_s  = miss_r + MR_W'(1'b1);
    err_inc_s   = (err_count_r == '1) ? err_count_r : err_count_r + ERR_W'(1'b1);

    if (bus.start) begin
      state_s        = ST_ACQUIRE;
      err_count_s    = '0;
      period_s       = '0;
      period_valid_s = 1'b0;
      miss_s         = '0;
      cycle_s        = '0;
      locked_s       = 1'b0;
    end else if (bus.in_valid) begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_ACQUIRE: begin
          if (bus.in_state == '0) begin
            zero_seen_s = 1'b1;
          end else begin
            origin_s = bus.in_state;
            ref_s    = in_step_s;
            cycle_s  = '0;
            miss_s   = '0;
            state_s  = ST_TRACK;
            locked_s = 1'b1;
          end
        end
        ST_TRACK: begin
          ref_s = ref_step_s;
          if (bus.in_state == ref_r) begin
            miss_s = '0;
            // A match on the origin word closes one full trip round the sequence.
            if (bus.in_state == origin_r) begin
              period_s       = cycle_r + W'(1'b1);
              period_valid_s = 1'b1;
              cycle_s        = '0;
            end else begin
              cycle_s = cycle_inc_s;
            end
          end else begin
            err_pulse_s = 1'b1;
            err_count_s = err_inc_s;
            cycle_s     = cycle_inc_s;
            miss_s      = miss_inc_s;
            if (miss_inc_s >= MR_W'(MISS_LIMIT)) begin
              state_s  = ST_ACQUIRE;
              locked_s = 1'b0;
            end else begin
              state_s = ST_TRACK;
            end
          end
        end
        default: begin
          state_s  = ST_IDLE;
          locked_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      ref_r          <= '0;
      origin_r       <= '0;
      cycle_r        <= '0;
      period_r       <= '0;
      period_valid_r <= 1'b0;
      miss_r         <= '0;
      err_count_r    <= '0;
      locked_r       <= 1'b0;
      err_pulse_r    <= 1'b0;
      zero_seen_r    <= 1'b0;
    end else begin
      state_r        <= state_s;
      ref_r          <= ref_s;
      origin_r       <= origin_s;
      cycle_r        <= cycle_s;
      period_r       <= period_s;
      period_valid_r <= period_valid_s;
      miss_r         <= miss_s;
      err_count_r    <= err_count_s;
      locked_r       <= locked_s;
      err_pulse_r    <= err_pulse_s;
      zero_seen_r    <= zero_seen_s;
    end
  end

  assign bus.locked       = locked_r;
  assign bus.err_pulse    = err_pulse_r;
  assign bus.err_count    = err_count_r;
  assign bus.zero_seen    = zero_seen_r;
  assign bus.period       = period_r;
  assign bus.period_valid = period_valid_r;

endmodule

// File: tb/tb_lfsr64_checker.sv
// Randomized and directed bench for lfsr64_checker: a 64-bit and a 4-bit
// instance run side by side against a word-level reference model.
module tb_lfsr64_checker;

  localparam logic [63:0] T64    = 64'hD800000000000000;
  localparam logic [63:0] T4     = 64'h000000000000000C;
  localparam logic [63:0] SEED64 = 64'h7A4E2A864EFACDC6;
  localparam int          MISS   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r0 = 1'b1, st0 = 1'b0, v0 = 1'b0;
  logic [63:0] s0 = 64'd0;
  logic        r1 = 1'b1, st1 = 1'b0, v1 = 1'b0;
  logic [63:0] s1 = 64'd0;

  lfsr64_checker_if #(.W(64), .ERR_W(16)) bus64 ();
  lfsr64_checker_if #(.W(4),  .ERR_W(16)) bus4 ();

  assign bus64.start    = st0;
  assign bus64.in_valid = v0;
  assign bus64.in_state = s0;
  assign bus4.start     = st1;
  assign bus4.in_valid  = v1;
  assign bus4.in_state  = s1[3:0];

  lfsr64_checker #(.W(64), .TAPS(64'hD800000000000000), .MISS_LIMIT(3), .ERR_W(16))
    dut64 (.clk(clk), .reset(r0), .bus(bus64));
  lfsr64_checker #(.W(4), .TAPS(4'b1100), .MISS_LIMIT(3), .ERR_W(16))
    dut4 (.clk(clk), .reset(r1), .bus(bus4));

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 acquiring, 2 tracking.
  typedef struct {
    int          mode;
    bit          locked;
    bit          err_pulse;
    bit          zero_seen;
    bit          pv;
    logic [63:0] err_count;
    logic [63:0] period;
    logic [63:0] expect_w;
    logic [63:0] origin;
    logic [63:0] cc;
    int          miss;
  } mdl_t;

  mdl_t m0, m1;

  function automatic logic [63:0] mask(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] m_next(input logic [63:0] s, input int w, input logic [63:0] taps);
    logic fb = 1'b0;
    for (int i = 0; i < w; i++) if (taps[i]) fb = fb ^ s[i];
    return ((s << 1) | {63'd0, fb}) & mask(w);
  endfunction

  task automatic model_step(inout mdl_t m, input bit rst, input bit st, input bit v,
                            input logic [63:0] s, input int w, input logic [63:0] taps);
    logic [63:0] mk = mask(w);
    m.err_pulse = 1'b0;
    m.zero_seen = 1'b0;
    if (rst) begin
      m.mode = 0; m.locked = 1'b0; m.pv = 1'b0; m.err_count = 64'd0; m.period = 64'd0;
      m.expect_w = 64'd0; m.origin = 64'd0; m.cc = 64'd0; m.miss = 0;
    end else if (st) begin
      m.mode = 1; m.locked = 1'b0; m.pv = 1'b0; m.err_count = 64'd0; m.period = 64'd0;
      m.cc = 64'd0; m.miss = 0;
    end else if (v && m.mode == 1) begin
      if (s == 64'd0) m.zero_seen = 1'b1;
      else begin
        m.origin = s; m.expect_w = m_next(s, w, taps); m.cc = 64'd0; m.miss = 0;
        m.mode = 2; m.locked = 1'b1;
      end
    end else if (v && m.mode == 2) begin
      if (s == m.expect_w) begin
        m.miss = 0;
        if (s == m.origin) begin
          m.period = (m.cc + 64'd1) & mk; m.pv = 1'b1; m.cc = 64'd0;
        end else if (m.cc != mk) m.cc = m.cc + 64'd1;
      end else begin
        m.err_pulse = 1'b1;
        if (m.err_count != 64'hFFFF) m.err_count = m.err_count + 64'd1;
        if (m.cc != mk) m.cc = m.cc + 64'd1;
        m.miss = m.miss + 1;
        if (m.miss >= MISS) begin m.mode = 1; m.locked = 1'b0; end
      end
      m.expect_w = m_next(m.expect_w, w, taps);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(m0, r0, st0, v0, s0, 64, T64);
    model_step(m1, r1, st1, v1, s1 & 64'hF, 4, T4);
    check_val("locked64",    64'(bus64.locked),       64'(m0.locked));
    check_val("err_pulse64", 64'(bus64.err_pulse),    64'(m0.err_pulse));
    check_val("err_count64", 64'(bus64.err_count),    m0.err_count);
    check_val("zero_seen64", 64'(bus64.zero_seen),    64'(m0.zero_seen));
    check_val("period64",    bus64.period,            m0.period);
    check_val("pvalid64",    64'(bus64.period_valid), 64'(m0.pv));
    check_val("locked4",     64'(bus4.locked),        64'(m1.locked));
    check_val("err_pulse4",  64'(bus4.err_pulse),     64'(m1.err_pulse));
    check_val("err_count4",  64'(bus4.err_count),     m1.err_count);
    check_val("zero_seen4",  64'(bus4.zero_seen),     64'(m1.zero_seen));
    check_val("period4",     64'(bus4.period),        m1.period);
    check_val("pvalid4",     64'(bus4.period_valid),  64'(m1.pv));
    r0 = 1'b0; st0 = 1'b0; v0 = 1'b0; s0 = 64'd0;
    r1 = 1'b0; st1 = 1'b0; v1 = 1'b0; s1 = 64'd0;
  endtask

  task automatic send0(input logic [63:0] s); v0 = 1'b1; s0 = s; tick(); endtask
  task automatic send1(input logic [63:0] s); v1 = 1'b1; s1 = s; tick(); endtask

  initial begin
    logic [63:0] g, w, g0, g1;
    int pulses;

    r0 = 1'b1; r1 = 1'b1; tick();
    r0 = 1'b1; r1 = 1'b1; tick();
    check_val("rst_locked", 64'(bus64.locked), 64'd0);
    check_val("rst_period", bus64.period, 64'd0);

    // Clean 64-bit stream.
    st0 = 1'b1; tick();
    g = SEED64; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      send0(g);
      if (i == 1) check_val("lock_first_word", 64'(bus64.locked), 64'd1);
      pulses += int'(bus64.err_pulse);
      g = m_next(g, 64, T64);
    end
    check_val("clean_err_count", 64'(bus64.err_count), 64'd0);
    check_val("clean_no_pulse", 64'(pulses), 64'd0);

    // Single corrupted word.
    st0 = 1'b1; tick();
    g = SEED64; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      w = (i == 6) ? (g ^ 64'd1) : g;
      send0(w);
      pulses += int'(bus64.err_pulse);
      g = m_next(g, 64, T64);
    end
    check_val("single_err_count", 64'(bus64.err_count), 64'd1);
    check_val("single_pulses", 64'(pulses), 64'd1);
    check_val("single_locked", 64'(bus64.locked), 64'd1);

    // Three consecutive corruptions drop lock, next good word relocks.
    st0 = 1'b1; tick();
    g = SEED64;
    for (int i = 1; i <= 12; i++) begin
      w = (i >= 6 && i <= 8) ? (g ^ 64'h100) : g;
      send0(w);
      if (i == 8) begin
        check_val("drop_err_count", 64'(bus64.err_count), 64'd3);
        check_val("drop_locked", 64'(bus64.locked), 64'd0);
      end
      if (i == 9) check_val("relock", 64'(bus64.locked), 64'd1);
      g = m_next(g, 64, T64);
    end

    // 4-bit period measurement.
    st1 = 1'b1; tick();
    g = 64'd1;
    for (int i = 1; i <= 32; i++) begin
      send1(g);
      if (i == 15) check_val("p4_not_yet", 64'(bus4.period_valid), 64'd0);
      if (i == 16) begin
        check_val("p4_valid", 64'(bus4.period_valid), 64'd1);
        check_val("p4_period16", 64'(bus4.period), 64'd15);
      end
      if (i == 31) check_val("p4_period31", 64'(bus4.period), 64'd15);
      g = m_next(g, 4, T4);
    end

    // Zero word in acquire, then start with a same-cycle word.
    st1 = 1'b1; tick();
    send1(64'd0);
    check_val("zero_pulse", 64'(bus4.zero_seen), 64'd1);
    send1(64'd1);
    check_val("zero_clear", 64'(bus4.zero_seen), 64'd0);
    check_val("zero_then_lock", 64'(bus4.locked), 64'd1);
    st1 = 1'b1; v1 = 1'b1; s1 = 64'd2; tick();
    tick();
    check_val("start_word_dropped", 64'(bus4.locked), 64'd0);

    // Reset mid-track abandons everything.
    st0 = 1'b1; tick();
    g = SEED64;
    for (int i = 0; i < 5; i++) begin send0(g); g = m_next(g, 64, T64); end
    r0 = 1'b1; tick();
    for (int i = 0; i < 18; i++) begin send0(g); g = m_next(g, 64, T64); end
    check_val("rst_mid_locked", 64'(bus64.locked), 64'd0);
    check_val("rst_mid_pvalid", 64'(bus64.period_valid), 64'd0);
    check_val("rst_mid_period", bus64.period, 64'd0);

    // Random traffic on both instances.
    st0 = 1'b1; st1 = 1'b1; tick();
    g0 = SEED64 ^ {32'd0, $urandom()};
    if (g0 == 64'd0) g0 = SEED64;
    g1 = 64'(($urandom_range(1, 15)));
    for (int n = 0; n < 800; n++) begin
      int a0, a1;
      a0 = $urandom_range(0, 99);
      a1 = $urandom_range(0, 99);
      if (a0 < 2) st0 = 1'b1;
      else if (a0 < 3) r0 = 1'b1;
      else if (a0 >= 30) begin
        v0 = 1'b1;
        if (a0 < 34) s0 = 64'd0;
        else if (a0 < 42) s0 = g0 ^ (64'd1 << $urandom_range(0, 63));
        else s0 = g0;
        g0 = m_next(g0, 64, T64);
      end
      if (a1 < 2) st1 = 1'b1;
      else if (a1 < 3) r1 = 1'b1;
      else if (a1 >= 25) begin
        v1 = 1'b1;
        if (a1 < 29) s1 = 64'd0;
        else if (a1 < 35) s1 = g1 ^ (64'd1 << $urandom_range(0, 3));
        else s1 = g1;
        g1 = m_next(g1, 4, T4);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
